bcd_display_conv: RTL
=====================

// Module: bcd_display_conv
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3) between the timer/counter core and lcd_top.
//  Replaces combinational /10 and %10 digit extraction with a registered, glitch-free digit set.
//  Converts on request or automatically when the value changes.
//  Outputs a leading-zero blank mask for the LCD digit drivers.
// PARAMETERS
//  BIN_W   10  width of binary input; must satisfy 2^BIN_W <= 10^DIGITS (elaboration check)
//  DIGITS  4   number of BCD digits produced
// PORTS
//  clk_50M    in   1          system clock, 50 MHz; all logic on rising edge
//  reset_btn  in   1          reset: synchronous, active-high
//  bin_in     in   BIN_W      binary value to convert (e.g. seconds / countdown_init)
//  start      in   1          one-cycle convert request; honoured only in IDLE
//  auto_en    in   1          1 = start automatically when bin_in != last converted value
//  frac_en    in   1          1 = value carries one decimal place; digit1 never blanked
//  busy       out  1          high from the cycle after acceptance until done
//  done       out  1          one-cycle pulse when bcd_out/blank are updated
//  bcd_out    out  4*DIGITS   packed BCD, digit0 = [3:0] (least significant)
//  blank      out  DIGITS     1 = digit is a leading zero, LCD shows it blank
// BEHAVIOUR
//  Reset (reset_btn=1 at a clock edge) clears all state regardless of FSM state:
//   - FSM -> IDLE; busy=0, done=0, bcd_out=0.
//   - blank = all ones except bit0 (and bit1 if frac_en); last_bin=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: trigger = start | (auto_en & bin_in != last_bin).
//     On trigger: sample bin_in into shift reg and last_bin, clear BCD scratch,
//     load cnt=BIN_W, go SHIFT.
//   - SHIFT (BIN_W cycles): each cycle, every scratch nibble >=5 gets +3.
//     Then {scratch,shift} <<= 1 and cnt decrements; leave when cnt reaches 1->0.
//   - DONE (1 cycle): copy scratch to bcd_out and recompute blank; done=1.
//     Return to IDLE.
//  Latency: trigger at edge N -> bcd_out valid and done=1 after edge N+BIN_W+1.
//   - For BIN_W=10 that is 11 cycles after acceptance.
//  busy=1 in SHIFT and DONE; 0 in IDLE.
//  start or bin_in changes while busy are ignored (no queueing).
//   - In auto mode a changed bin_in is picked up in the next IDLE cycle via last_bin compare.
//  bcd_out/blank hold their last value during a conversion; never partially updated.
//  Blank rule: digit k blanked iff all digits >= k are zero, for k >= 1 (k >= 2 if frac_en).
//   - digit0 is never blanked.
//  frac_en is sampled in DONE, not at trigger.
//  Add-3 is on 4-bit nibbles; scratch width 4*DIGITS; no carry out of top nibble by constraint.
//  start asserted with bin_in equal to last_bin still converts (forced refresh).
// STRUCTURE
//  Shared include lcd_defs.vh:
//   - FSM state localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
//   - BCD_NIB_W=4; blank-digit code used by lcd_top
//  One sub-module: bcd_add3 (4-bit comb: out = in>=5 ? in+3 : in), instantiated DIGITS times via generate.
//  Everything else (FSM, counter, shift regs, blank logic) stays in bcd_display_conv.
// TESTING
//  T1 reset then start, bin_in=0, frac_en=0:
//     done after 11 clks; bcd_out=16'h0000, blank=4'b1110.
//  T2 start, bin_in=999:
//     bcd_out=16'h0999, blank=4'b1000.
//  T3 start, bin_in=1023:
//     bcd_out=16'h1023, blank=4'b0000.
//  T4 start, bin_in=5, frac_en=1:
//     bcd_out=16'h0005, blank=4'b1100 (shown as 0.5).
//  T5 auto_en=1, bin_in 30 -> 29:
//     one conversion per change; bcd_out=16'h0029.
//     bin_in held -> no further done pulses.
//  T6 start at bin_in=42; at 3rd SHIFT cycle pulse start with bin_in=77; at 5th SHIFT cycle reset:
//     busy=0, done=0, bcd_out=0 on next edge.
//     Second start ignored; no done pulse is produced for either conversion.

Source files
------------

// File: rtl/bcd_display_conv_pkg.sv
// Shared definitions for the binary-to-BCD display path.
// Includes the FSM encoding, nibble width, the LCD blank code and the elaboration helper.
package bcd_display_conv_pkg;

  localparam int unsigned BCD_NIB_W  = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_display_conv_add3.sv
// Double-dabble correction cell.
// A nibble of 5 or more gets +3 so that the following left shift carries into the next decimal digit.
module bcd_add3
  import bcd_display_conv_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] nib,
  output logic [BCD_NIB_W-1:0] adj
);

  always_comb begin
    adj = (nib >= BCD_NIB_W'(5)) ? nib + BCD_NIB_W'(3) : nib;
  end

endmodule

// File: rtl/bcd_display_conv.sv
// Sequential shift-add-3 binary-to-BCD converter with a registered digit set.
// Also produces the leading-zero blank mask for the LCD digit drivers.
module bcd_display_conv
  import bcd_display_conv_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk_50M,
  input  logic                          reset_btn,
  input  logic [BIN_W-1:0]              bin_in,
  input  logic                          start,
  input  logic                          auto_en,
  input  logic                          frac_en,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_NIB_W*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]             blank
);

  localparam int unsigned SCR_W = BCD_NIB_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if ((64'd1 << BIN_W) > pow10(DIGITS)) begin : g_range_check
    $error("bcd_display_conv: 2**BIN_W exceeds 10**DIGITS");
  end

  state_t             state;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   adj;
  logic [BIN_W-1:0]   shift;
  logic [BIN_W-1:0]   last_bin;
  logic [CNT_W-1:0]   cnt;
  logic               trigger;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (scratch[i*BCD_NIB_W +: BCD_NIB_W]),
      .adj (adj[i*BCD_NIB_W +: BCD_NIB_W])
    );
  end

  always_comb begin
    trigger = start | (auto_en & (bin_in != last_bin));
  end

  // Scan from the top digit down: a digit is blank while every digit above it (and itself) is zero.
  function automatic logic [DIGITS-1:0] calc_blank(input logic [SCR_W-1:0] v, input logic frac);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS; i > 1; i--) begin
      zero_above = zero_above & (v[(i-1)*BCD_NIB_W +: BCD_NIB_W] == '0);
      m[i-1]     = zero_above & ~(frac & (i == 2));
    end
    return m;
  endfunction

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      blank    <= calc_blank('0, frac_en);
      last_bin <= '0;
      scratch  <= '0;
      shift    <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            shift    <= bin_in;
            last_bin <= bin_in;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shift} <= {adj, shift} << 1;
          cnt              <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          bcd_out <= scratch;
          blank   <= calc_blank(scratch, frac_en);
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
